// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit: sequential 32-cycle shift/add multiplier with the HI/LO
// result registers of the MIPS datapath.
//   clk, rst_n       clock, asynchronous active-low reset
//   start            begin a multiply (accepted in IDLE only)
//   signed_op        1 = MULT (signed), 0 = MULTU; sampled with start
//   rs_val, rt_val   operands; sampled with start
//   mthi, mtlo       write wdata to HI/LO (IDLE only, start low)
//   wdata            move data
//   hi, lo           HI/LO registers
//   busy             multiply in progress
//   done             one-cycle pulse after HI/LO updated by a multiply
module hilo_mult_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned AW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [AW-1:0]    acc_q,    acc_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             neg_q,    neg_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [AW-1:0]    result;

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    addend   = '0;
    sum      = '0;
    result   = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Signed operands enter the unsigned core as magnitudes;
          // |min-int| wraps to itself, which is correct read as unsigned.
          mcand_d  = (signed_op && rs_val[WIDTH-1]) ? (~rs_val + WIDTH'(1)) : rs_val;
          mplier_d = (signed_op && rt_val[WIDTH-1]) ? (~rt_val + WIDTH'(1)) : rt_val;
          neg_d    = signed_op & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = S_RUN;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end

      S_RUN: begin
        addend  = mplier_q[count_q] ? mcand_q : '0;
        // Carry out of the upper-half add lands in bit AW-1 after the shift
        sum     = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, addend};
        acc_d   = {sum, acc_q[WIDTH-1:1]};
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        result  = neg_q ? (~acc_q + AW'(1)) : acc_q;
        hi_d    = result[AW-1:WIDTH];
        lo_d    = result[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Self-checking bench for hilo_mult_unit: directed and random multiplies
// against a 64-bit arithmetic reference, moves, ignored inputs and reset.
module tb_hilo_mult_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  int          n_tests;
  int          n_fail;

  hilo_mult_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .signed_op (signed_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: full 64-bit product of the (sign- or zero-) extended operands
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  task automatic move(input logic do_hi, input logic do_lo, input logic [31:0] v);
    @(negedge clk);
    mthi  = do_hi;
    mtlo  = do_lo;
    wdata = v;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    if (do_hi) exp_hi = v;
    if (do_lo) exp_lo = v;
    chk("move_hi", 64'(hi), 64'(exp_hi));
    chk("move_lo", 64'(lo), 64'(exp_lo));
    chk("move_done", 64'(done), 64'd0);
    chk("move_busy", 64'(busy), 64'd0);
  endtask

  // One multiply; optionally pokes start/mthi mid-run, or mtlo with start
  task automatic mult(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input bit inject, input bit with_mtlo);
    logic [63:0] p;
    p = ref_prod(a, b, s);
    @(negedge clk);
    rs_val = a;  rt_val = b;  signed_op = s;  start = 1'b1;
    mtlo = with_mtlo;  wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;  mtlo = 1'b0;
    rs_val = $urandom;  rt_val = $urandom;  signed_op = 1'($urandom);
    chk("e0_busy", 64'(busy), 64'd1);
    chk("e0_lo_hold", 64'(lo), 64'(exp_lo));
    for (int c = 1; c <= 32; c++) begin
      if (inject && c == 5) begin
        start = 1'b1;  mthi = 1'b1;  wdata = $urandom;
        rs_val = $urandom;  rt_val = $urandom;
      end else begin
        start = 1'b0;  mthi = 1'b0;
      end
      @(negedge clk);
      chk("run_busy", 64'(busy), 64'd1);
      chk("run_done", 64'(done), 64'd0);
      chk("run_hi_hold", 64'(hi), 64'(exp_hi));
      chk("run_lo_hold", 64'(lo), 64'(exp_lo));
    end
    start = 1'b0;  mthi = 1'b0;
    @(negedge clk);
    exp_hi = p[63:32];
    exp_lo = p[31:0];
    chk("res_busy", 64'(busy), 64'd0);
    chk("res_done", 64'(done), 64'd1);
    chk("res_hi", 64'(hi), 64'(exp_hi));
    chk("res_lo", 64'(lo), 64'(exp_lo));
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("post_hi", 64'(hi), 64'(exp_hi));
  endtask

  initial begin
    n_tests = 0;  n_fail = 0;
    rst_n = 1'b0;  start = 1'b0;  signed_op = 1'b0;
    rs_val = '0;  rt_val = '0;  mthi = 1'b0;  mtlo = 1'b0;  wdata = '0;
    exp_hi = '0;  exp_lo = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;

    move(1'b1, 1'b0, 32'h1234_5678);
    move(1'b0, 1'b1, 32'h9ABC_DEF0);
    move(1'b1, 1'b1, 32'h55AA_33CC);

    mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    chk("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_max_lo", 64'(lo), 64'h0000_0001);
    mult(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, 1'b0);
    chk("mult_m3x5_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_m3x5_lo", 64'(lo), 64'hFFFF_FFF1);
    mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    chk("mult_m1m1_hi", 64'(hi), 64'd0);
    chk("mult_m1m1_lo", 64'(lo), 64'd1);
    mult(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    chk("mult_min2_hi", 64'(hi), 64'h4000_0000);
    chk("mult_min2_lo", 64'(lo), 64'd0);
    mult(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    chk("multu_min2_hi", 64'(hi), 64'h4000_0000);
    mult(32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b0);
    chk("mult_minx1_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_minx1_lo", 64'(lo), 64'h8000_0000);

    // Moves, then start/mthi poked mid-run, then start with mtlo together
    move(1'b1, 1'b0, 32'h1234_5678);
    move(1'b0, 1'b1, 32'h9ABC_DEF0);
    mult(32'h0001_2345, 32'h0000_6789, 1'b0, 1'b1, 1'b0);
    mult(32'hCAFE_0001, 32'h0000_0003, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      mult($urandom, $urandom, 1'($urandom), 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    rs_val = 32'hFFFF_0000;  rt_val = 32'h0000_FFFF;  signed_op = 1'b0;  start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_hi = '0;  exp_lo = '0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mult(32'd7, 32'd6, 1'b0, 1'b0, 1'b0);
    chk("after_abort_hi", 64'(hi), 64'd0);
    chk("after_abort_lo", 64'(lo), 64'd42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
